// File: rtl/snake_move_sched.sv
// snake_move_sched
//   Sits between the four raw direction buttons and the snake engine.
//   Buttons are synchronised and debounced. Press pulses are arbitrated
//   (up > right > down > left) into a 2-entry turn queue that rejects
//   repeats and reversals. One move command per game tick is issued to the
//   engine over a valid/ready handshake. Lifecycle: IDLE -> RUN <-> WAIT -> OVER.
//
//   Optional feature (macro SNAKE_SPEEDUP_EN): each grow pulse in RUN/WAIT
//   shortens the move period by SPEED_STEP, down to MIN_TICK_CYC. The new
//   period takes effect from the next timer wrap.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   btn_up/right/down/left  raw asynchronous active-high buttons
//   game_over           engine collision level
//   grow                engine food-eaten pulse
//   step_valid/ready    move command handshake
//   step_dir            00 up, 01 right, 10 down, 11 left
//   running             high in RUN or WAIT
module snake_move_sched #(
    parameter int unsigned DEBOUNCE_CYC = 120000,
    parameter int unsigned TICK_CYC     = 1200000,
    parameter int unsigned MIN_TICK_CYC = 300000,
    parameter int unsigned SPEED_STEP   = 60000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       game_over,
    input  logic       grow,
    output logic       step_valid,
    input  logic       step_ready,
    output logic [1:0] step_dir,
    output logic       running
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_OVER = 2'd3
    } state_t;

    localparam logic [1:0] DIR_RIGHT = 2'b01;

    state_t      state;
    logic [3:0]  sync_a;
    logic [3:0]  sync_b;
    logic [3:0]  db_state;
    logic [3:0]  press;
    logic [31:0] db_cnt [4];

    logic [1:0]  q [2];
    logic [1:0]  q_cnt;
    logic [1:0]  cur_dir;
    logic [31:0] timer;
    logic [31:0] period;

    logic        win_valid;
    logic [1:0]  win_dir;
    logic [1:0]  ref_dir;
    logic        accept;
    logic        active;
    logic        tick;
    logic        pop;
    logic        push;

    // Bit order of the button vectors: [0] up, [1] right, [2] down, [3] left,
    // so a bit index equals its direction code.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a   <= '0;
            sync_b   <= '0;
            db_state <= '0;
            press    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a <= {btn_left, btn_down, btn_right, btn_up};
            sync_b <= sync_a;
            press  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync_b[i] != db_state[i]) begin
                    if (db_cnt[i] == DEBOUNCE_CYC - 32'd1) begin
                        db_state[i] <= ~db_state[i];
                        db_cnt[i]   <= '0;
                        press[i]    <= ~db_state[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 32'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        win_valid = |press;
        win_dir   = 2'd0;
        if (press[0])      win_dir = 2'd0;
        else if (press[1]) win_dir = 2'd1;
        else if (press[2]) win_dir = 2'd2;
        else if (press[3]) win_dir = 2'd3;

        ref_dir = cur_dir;
        if (q_cnt == 2'd1)      ref_dir = q[0];
        else if (q_cnt == 2'd2) ref_dir = q[1];

        accept = win_valid && (win_dir != ref_dir) &&
                 ((win_dir ^ ref_dir) != 2'b10) && (q_cnt != 2'd2);
        active = (state == S_RUN) || (state == S_WAIT);
        tick   = active && (timer == period - 32'd1);
        pop    = (state == S_RUN) && tick && (q_cnt != 2'd0) && !game_over;
        push   = active && accept && !game_over;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            q_cnt      <= '0;
            q[0]       <= '0;
            q[1]       <= '0;
            cur_dir    <= DIR_RIGHT;
            timer      <= '0;
            step_valid <= 1'b0;
            step_dir   <= DIR_RIGHT;
            running    <= 1'b0;
        end else begin
            timer <= (active && !tick) ? timer + 32'd1 : '0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        q[0]    <= win_dir;
                        q_cnt   <= 2'd1;
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                end
                S_RUN, S_WAIT: begin
                    if (game_over) begin
                        state      <= S_OVER;
                        step_valid <= 1'b0;
                        running    <= 1'b0;
                    end else begin
                        if (pop) cur_dir <= q[0];
                        // Pop together with push only happens with one entry
                        // (a full queue rejects the push), so the pushed
                        // direction simply replaces the head.
                        if (pop && push) begin
                            q[0] <= win_dir;
                        end else if (pop) begin
                            q[0]  <= q[1];
                            q_cnt <= q_cnt - 2'd1;
                        end else if (push) begin
                            q[q_cnt[0]] <= win_dir;
                            q_cnt       <= q_cnt + 2'd1;
                        end
                        if (state == S_RUN) begin
                            if (tick) begin
                                state      <= S_WAIT;
                                step_valid <= 1'b1;
                                step_dir   <= pop ? q[0] : cur_dir;
                            end
                        end else if (step_valid && step_ready) begin
                            step_valid <= 1'b0;
                            state      <= S_RUN;
                        end
                    end
                end
                S_OVER: begin
                    step_valid <= 1'b0;
                    if (win_valid) begin
                        state    <= S_IDLE;
                        q_cnt    <= '0;
                        cur_dir  <= DIR_RIGHT;
                        step_dir <= DIR_RIGHT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SNAKE_SPEEDUP_EN
    // period_next collects grow events; period only reloads at a wrap so the
    // interval in progress keeps its length.
    logic [31:0] period_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            period      <= TICK_CYC;
            period_next <= TICK_CYC;
        end else if (state == S_OVER && win_valid) begin
            period      <= TICK_CYC;
            period_next <= TICK_CYC;
        end else begin
            if (tick) period <= period_next;
            if (grow && active) begin
                period_next <= (period_next >= MIN_TICK_CYC + SPEED_STEP) ?
                               period_next - SPEED_STEP : MIN_TICK_CYC;
            end
        end
    end
`else
    assign period = TICK_CYC;

    logic unused_cfg;
    assign unused_cfg = ^{grow, MIN_TICK_CYC, SPEED_STEP};
`endif

endmodule
